// File: rtl/div_display_pkg.sv
// Shared types and constants for the divider result display.
// Leading-zero blanking is enabled by defining DIV_DISPLAY_LZB_EN.
package div_display_pkg;

   // FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t StIdle    = 2'd0;
   localparam state_t StConvert = 2'd1;
   localparam state_t StLoad    = 2'd2;

   // Per-digit display codes: 0..9 are BCD values
   typedef logic [3:0] digit_t;
   localparam digit_t DigMinus = 4'hA;
   localparam digit_t DigBlank = 4'hF;

   localparam int unsigned BcdDigits = 6;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] Seg0     = 7'h40;
   localparam logic [6:0] Seg1     = 7'h79;
   localparam logic [6:0] Seg2     = 7'h24;
   localparam logic [6:0] Seg3     = 7'h30;
   localparam logic [6:0] Seg4     = 7'h19;
   localparam logic [6:0] Seg5     = 7'h12;
   localparam logic [6:0] Seg6     = 7'h02;
   localparam logic [6:0] Seg7     = 7'h78;
   localparam logic [6:0] Seg8     = 7'h00;
   localparam logic [6:0] Seg9     = 7'h10;
   localparam logic [6:0] SegMinus = 7'h3F;
   localparam logic [6:0] SegBlank = 7'h7F;

   // Digit code to segment pattern; unknown codes show blank
   function automatic logic [6:0] seg_decode(input digit_t code);
      logic [6:0] s;
      case (code)
         4'd0:     s = Seg0;
         4'd1:     s = Seg1;
         4'd2:     s = Seg2;
         4'd3:     s = Seg3;
         4'd4:     s = Seg4;
         4'd5:     s = Seg5;
         4'd6:     s = Seg6;
         4'd7:     s = Seg7;
         4'd8:     s = Seg8;
         4'd9:     s = Seg9;
         DigMinus: s = SegMinus;
         default:  s = SegBlank;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Sequential shift-add-3 binary to BCD converter, one shift per enabled cycle.
module bin_to_bcd_serial
   import div_display_pkg::*;
#(
   parameter int unsigned RESULT_W = 18
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_load,
   input  logic [RESULT_W-1:0]      i_mag,
   input  logic                     i_step,
   output logic [4*BcdDigits-1:0]   o_bcd,
   output logic                     o_done
);

   localparam int unsigned StepW = $clog2(RESULT_W);
   localparam int unsigned ShW   = 4 * BcdDigits + RESULT_W;

   logic [StepW-1:0]       r_step;
   logic [4*BcdDigits-1:0] r_bcd;
   logic [RESULT_W-1:0]    r_mag;
   logic [4*BcdDigits-1:0] w_bcd_adj;
   logic [ShW-1:0]         w_shift;

   // Add 3 to every nibble >= 5, then shift the joint vector left by one
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < BcdDigits; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
      w_shift = {w_bcd_adj, r_mag} << 1;
   end

   // Done pulses on the cycle the final shift is performed
   assign o_done = i_step && (r_step == StepW'(RESULT_W - 1));
   assign o_bcd  = r_bcd;

   // Step counter and shift datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_step <= '0;
         r_bcd  <= '0;
         r_mag  <= '0;
      end else if (i_load) begin
         r_step <= '0;
         r_bcd  <= '0;
         r_mag  <= i_mag;
      end else if (i_step) begin
         r_step         <= r_step + 1'b1;
         {r_bcd, r_mag} <= w_shift;
      end
   end

endmodule

// File: rtl/div_result_display.sv
// Captures signed divider results, converts them to BCD and scans an
// 8-digit active-low seven-segment display.
// Define DIV_DISPLAY_LZB_EN to blank leading zeros in digits 5..1.
module div_result_display
   import div_display_pkg::*;
#(
   parameter int unsigned RESULT_W     = 18,
   parameter int unsigned REFRESH_BITS = 17
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [RESULT_W-1:0] result_in,
   input  logic                result_valid,
   output logic                busy,
   output logic [7:0]          an,
   output logic [6:0]          seg,
   output logic                dp
);

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     r_pend_valid;
   logic [RESULT_W-1:0]      r_pend_data;
   logic                     w_pend_valid_next;
   logic [RESULT_W-1:0]      w_pend_data_next;
   logic                     r_sign;
   logic [7:0][3:0]          r_digit;
   logic [7:0][3:0]          w_digit_new;
   logic [REFRESH_BITS-1:0]  r_refresh;
   logic [7:0]               r_an;
   logic [6:0]               r_seg;
   logic [2:0]               w_idx;

   logic                     w_start_new;
   logic                     w_start_pend;
   logic                     w_load;
   logic [RESULT_W-1:0]      w_src;
   logic [RESULT_W-1:0]      w_mag;
   logic                     w_step;
   logic                     w_done;
   logic [4*BcdDigits-1:0]   w_bcd;
   logic                     w_lead;

   // A pending result takes priority at LOAD; a fresh strobe at LOAD with
   // nothing pending starts directly so busy never drops in between.
   always_comb begin
      w_start_new  = result_valid &&
                     ((r_state == StIdle) || ((r_state == StLoad) && !r_pend_valid));
      w_start_pend = (r_state == StLoad) && r_pend_valid;
      w_load       = w_start_new || w_start_pend;
      w_src        = w_start_pend ? r_pend_data : result_in;
      // Full-width negation keeps -2^(W-1) representable as an unsigned magnitude
      w_mag        = w_src[RESULT_W-1] ? (~w_src + RESULT_W'(1)) : w_src;
      w_step       = (r_state == StConvert);
   end

   bin_to_bcd_serial #(
      .RESULT_W (RESULT_W)
   ) u_bcd (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_mag  (w_mag),
      .i_step (w_step),
      .o_bcd  (w_bcd),
      .o_done (w_done)
   );

   // Next-state logic for the FSM
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:    if (result_valid) w_state_next = StConvert;
         StConvert: if (w_done)       w_state_next = StLoad;
         StLoad:    w_state_next = w_load ? StConvert : StIdle;
         default:   w_state_next = StIdle;
      endcase
   end

   // One-entry pending slot; the newest strobe always wins
   always_comb begin
      w_pend_valid_next = r_pend_valid;
      w_pend_data_next  = r_pend_data;
      if (w_start_pend) begin
         w_pend_valid_next = result_valid;
         if (result_valid) w_pend_data_next = result_in;
      end else if (result_valid && !w_start_new && (r_state != StIdle)) begin
         w_pend_valid_next = 1'b1;
         w_pend_data_next  = result_in;
      end
   end

   // Build the digit codes written during LOAD
   always_comb begin
      w_digit_new = '1;
      w_lead      = 1'b1;
      for (int i = BcdDigits - 1; i >= 0; i--) begin
         w_digit_new[i] = w_bcd[4*i +: 4];
`ifdef DIV_DISPLAY_LZB_EN
         if (i > 0) begin
            w_lead = w_lead && (w_bcd[4*i +: 4] == 4'd0);
            if (w_lead) w_digit_new[i] = DigBlank;
         end
`endif
      end
      w_digit_new[6] = DigBlank;
      w_digit_new[7] = r_sign ? DigMinus : DigBlank;
   end

   // FSM, pending slot, sign and digit registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_sign       <= 1'b0;
         r_digit      <= '1;
      end else begin
         r_state      <= w_state_next;
         r_pend_valid <= w_pend_valid_next;
         r_pend_data  <= w_pend_data_next;
         if (w_load)              r_sign  <= w_src[RESULT_W-1];
         if (r_state == StLoad)   r_digit <= w_digit_new;
      end
   end

   assign w_idx = r_refresh[REFRESH_BITS-1 -: 3];

   // Free-running refresh counter and registered scan outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_refresh <= '0;
         r_an      <= 8'hFE;
         r_seg     <= SegBlank;
      end else begin
         r_refresh <= r_refresh + 1'b1;
         r_an      <= ~(8'b1 << w_idx);
         r_seg     <= seg_decode(r_digit[w_idx]);
      end
   end

   assign busy = (r_state != StIdle);
   assign an   = r_an;
   assign seg  = r_seg;
   assign dp   = 1'b1;

endmodule
